// File: rtl/led_matrix_scan_ctrl.sv
// Column-scan sequencer for a ROWS x COLS LED dot matrix with a double-buffered frame.
// Optional LED_MATRIX_BRIGHTNESS_EN adds a per-frame brightness limit on the drive window.
module led_matrix_scan_ctrl #(
  parameter int unsigned ROWS      = 5,
  parameter int unsigned COLS      = 7,
  parameter int unsigned TICK_DIV  = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROWS*COLS-1:0]     frame_in,
  input  logic                     frame_valid,
  output logic                     frame_ready,
`ifdef LED_MATRIX_BRIGHTNESS_EN
  input  logic [2:0]               brightness,
`endif
  output logic [COLS-1:0]          col_n,
  output logic [ROWS-1:0]          row,
  output logic [$clog2(COLS)-1:0]  col_idx,
  output logic                     frame_start
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned FW = ROWS * COLS;

  // p/col hold the slot position currently shown on the outputs
  logic [PW-1:0] p, next_p;
  logic [CW-1:0] col, next_col;
  logic          running;
  logic [FW-1:0] display, shadow, next_display;
  logic          pending;
  logic          last_p, last_col, boundary, swap, xfer, drive;
  logic [COLS-1:0] next_col_n;
  logic [ROWS-1:0] next_row;
  logic            next_frame_start;
`ifdef LED_MATRIX_BRIGHTNESS_EN
  logic [2:0] bright_reg, next_bright;
`endif

  // Next slot position, buffer swap and registered output values
  always_comb begin
    last_p   = (p == PW'(TICK_DIV - 1));
    last_col = (col == CW'(COLS - 1));
    boundary = running && last_p && last_col;
    swap     = boundary && pending;
    xfer     = frame_valid && frame_ready;
    next_p   = '0;
    next_col = '0;
    if (running) begin
      next_p   = last_p ? '0 : p + PW'(1);
      next_col = last_p ? (last_col ? '0 : col + CW'(1)) : col;
    end
    next_display = swap ? shadow : display;
    drive        = (next_p >= PW'(BLANK_CYC));
`ifdef LED_MATRIX_BRIGHTNESS_EN
    next_bright = boundary ? brightness : bright_reg;
    drive       = drive && (3'(next_p) <= next_bright);
`endif
    next_frame_start = (next_p == '0) && (next_col == '0);
    next_col_n = '1;
    next_row   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (drive && (next_col == CW'(c))) begin
        next_col_n[c] = 1'b0;
        next_row      = next_display[c*ROWS +: ROWS];
      end
    end
  end

  // Counters, frame buffers, handshake and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p           <= '0;
      col         <= '0;
      running     <= 1'b0;
      display     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_ready <= 1'b1;
      col_n       <= '1;
      row         <= '0;
      col_idx     <= '0;
      frame_start <= 1'b0;
`ifdef LED_MATRIX_BRIGHTNESS_EN
      bright_reg  <= 3'd7;
`endif
    end else begin
      p           <= next_p;
      col         <= next_col;
      running     <= 1'b1;
      display     <= next_display;
      col_n       <= next_col_n;
      row         <= next_row;
      col_idx     <= next_col;
      frame_start <= next_frame_start;
`ifdef LED_MATRIX_BRIGHTNESS_EN
      bright_reg  <= next_bright;
`endif
      // ready implies not pending, so a transfer and a swap never coincide
      if (xfer) begin
        shadow      <= frame_in;
        pending     <= 1'b1;
        frame_ready <= 1'b0;
      end else if (swap) begin
        pending     <= 1'b0;
        frame_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: directed phases plus random frame traffic against a slot/frame model.
module tb_led_matrix_scan_ctrl;

  localparam int unsigned ROWS  = 5;
  localparam int unsigned COLS  = 7;
  localparam int unsigned TDIV  = 16;
  localparam int unsigned BLANK = 2;
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned FRAME = COLS * TDIV;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   frame_in = '0;
  logic           frame_valid = 1'b0;
  logic           frame_ready;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row;
  logic [2:0]     col_idx;
  logic           frame_start;
`ifdef LED_MATRIX_BRIGHTNESS_EN
  logic [2:0]     brightness = 3'd7;
`endif

  led_matrix_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready),
`ifdef LED_MATRIX_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .col_n(col_n), .row(row), .col_idx(col_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: k counts clocks since reset release; frame buffers follow the handshake rules.
  int           k = 0;
  logic [N-1:0] m_display = '0;
  logic [N-1:0] m_shadow = '0;
  logic         m_pending = 1'b0;
  logic         accepted = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_n"}, 64'(col_n), 64'(7'h7F));
    chk({tag, "_row"}, 64'(row), 64'd0);
    chk({tag, "_ready"}, 64'(frame_ready), 64'd1);
    chk({tag, "_fstart"}, 64'(frame_start), 64'd0);
    chk({tag, "_col_idx"}, 64'(col_idx), 64'd0);
  endtask

  task automatic check_slot();
    int p, c;
    logic [COLS-1:0] e_col_n;
    logic [ROWS-1:0] e_row;
    p = k % TDIV;
    c = (k / TDIV) % COLS;
    e_col_n = '1;
    e_row   = '0;
    if (p >= BLANK) begin
      e_col_n[c] = 1'b0;
      e_row      = m_display[c*ROWS +: ROWS];
    end
    chk("col_n", 64'(col_n), 64'(e_col_n));
    chk("row", 64'(row), 64'(e_row));
    chk("col_idx", 64'(col_idx), 64'(c));
    chk("frame_start", 64'(frame_start), 64'((k % FRAME) == 0));
    chk("frame_ready", 64'(frame_ready), 64'(!m_pending));
  endtask

  // One displayed clock: check it, drive inputs sampled at its closing edge, advance the model
  task automatic step(input logic v, input logic [N-1:0] d);
    logic swap, xfer;
    @(negedge clk);
    check_slot();
    frame_valid = v;
    frame_in    = d;
    swap = ((k % FRAME) == FRAME - 1) && m_pending;
    xfer = v && !m_pending;
    if (swap) begin
      m_display = m_shadow;
      m_pending = 1'b0;
    end
    if (xfer) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    accepted = xfer;
    k++;
  endtask

  function automatic logic [N-1:0] rand_frame();
    return N'({$urandom, $urandom});
  endfunction

  initial begin
    logic [N-1:0] fa, fb;
    int budget;

    // Reset held
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;

    // Idle frame: columns cycle with blank rows
    repeat (FRAME) step(1'b0, '0);

    // Single-column pattern in column 0
    fa = N'(5'b10101);
    step(1'b1, fa);
    repeat (2 * FRAME) step(1'b0, '0);

    // Back-to-back frames with valid held high
    fa = rand_frame();
    fb = rand_frame();
    budget = 0;
    do begin step(1'b1, fa); budget++; end while (!accepted && budget < 10);
    budget = 0;
    do begin step(1'b1, fb); budget++; end while (!accepted && budget < 3 * FRAME);
    chk("b2b_accept", 64'(accepted), 64'd1);
    repeat (2 * FRAME) step(1'b0, '0);

    // Random traffic over several frames
    repeat (4 * FRAME) step(($urandom_range(0, 7) == 0), rand_frame());

    // Make sure a frame is on display, then reset mid-slot at column 3, p=9
    step(1'b1, rand_frame());
    while ((k % FRAME) != 0) step(1'b0, '0);
    repeat (FRAME) step(1'b0, '0);
    while ((k % FRAME) != 3 * TDIV + 9) step(1'b0, '0);
    @(negedge clk);
    check_slot();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    k = 0;
    m_display = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Scan restarts at column 0 with an empty display
    repeat (FRAME + 20) step(1'b0, '0);
    repeat (FRAME) step(($urandom_range(0, 3) == 0), rand_frame());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
